pseudo_clock_multi: RTL and testbench

Multi-channel successor of the single-channel pseudo-clock generator. Produces C_CH independent gated pseudo-clocks from sysClk, each with a runtime half-period divisor, start phase offset and optional burst length. Each channel emits one-cycle edge and post-edge strobes. Sits next to emulated-clock logic and drives clock-enable fabric for emulated peripherals; its outputs are data signals, not BUFG clocks.

---
 rtl/pseudo_clock_multi.sv | 157 +++++++++++++++
 tb/tb_pseudo_clock_multi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pseudo_clock_multi.sv
// Purpose : C_CH independent gated pseudo-clocks derived from sysClk, each with its own half-divisor, start phase and burst length.
// Latency : chStart sampled at edge T with phase P gives the first gatedPseudoClock rise at edge T+1+P; all strobes are registered.
// Backpr. : none; a config write to a busy or nonexistent channel is dropped, and chStart to a busy channel is ignored.
//
// Ports:
//   sysClk, sysRst                   clock, synchronous active-high reset
//   cfgWe/cfgCh/cfgHdiv/cfgPhase/cfgBurst
//                                    per-channel config write (IDLE channels only)
//   chStart, chStop                  per-channel level-sampled run control
//   gatedPseudoClock                 per-channel pseudo-clock (data signal)
//   rEdgePulse/fEdgePulse            first high / first low cycle strobes
//   postREdgePulse/postFEdgePulse    the same strobes delayed one cycle
//   chBusy, chDone                   channel active, one-cycle end-of-run pulse
module pseudo_clock_multi #(
  parameter int C_CH           = 4,
  parameter int C_CLK_HDIV_LEN = 32,
  parameter int C_CLK_HDIV_N   = 3,
  parameter int C_BURST_LEN    = 16,
  localparam int CH_W          = (C_CH > 1) ? $clog2(C_CH) : 1
) (
  input  logic                      sysClk,
  input  logic                      sysRst,
  input  logic                      cfgWe,
  input  logic [CH_W-1:0]           cfgCh,
  input  logic [C_CLK_HDIV_LEN-1:0] cfgHdiv,
  input  logic [C_CLK_HDIV_LEN-1:0] cfgPhase,
  input  logic [C_BURST_LEN-1:0]    cfgBurst,
  input  logic [C_CH-1:0]           chStart,
  input  logic [C_CH-1:0]           chStop,
  output logic [C_CH-1:0]           gatedPseudoClock,
  output logic [C_CH-1:0]           rEdgePulse,
  output logic [C_CH-1:0]           fEdgePulse,
  output logic [C_CH-1:0]           postREdgePulse,
  output logic [C_CH-1:0]           postFEdgePulse,
  output logic [C_CH-1:0]           chBusy,
  output logic [C_CH-1:0]           chDone
);

  localparam int H = C_CLK_HDIV_LEN;
  localparam int B = C_BURST_LEN;

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_RUN, S_STOP} state_t;

  for (genvar g = 0; g < C_CH; g++) begin : g_ch
    state_t         st_q, st_d;
    logic [H-1:0]   hdiv_q, hdiv_d, phase_q, phase_d, cnt_q, cnt_d;
    logic [B-1:0]   burst_q, burst_d, edges_q, edges_d;
    logic           hi_q, hi_d, re_q, re_d, fe_q, fe_d, done_q, done_d;
    logic           pre_q, pfe_q;
    logic           cfg_hit;
    logic           run_end;

    // Out-of-range cfgCh never matches any channel index, so it is dropped here.
    assign cfg_hit = cfgWe && (cfgCh == CH_W'(g)) && (st_q == S_IDLE);
    // Conditions that turn a would-be rising edge into the return to IDLE.
    assign run_end = (st_q == S_STOP) || chStop[g] ||
                     ((burst_q != '0) && (edges_q == burst_q));

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      edges_d = edges_q;
      re_d    = 1'b0;
      fe_d    = 1'b0;
      done_d  = 1'b0;
      hdiv_d  = cfg_hit ? cfgHdiv  : hdiv_q;
      phase_d = cfg_hit ? cfgPhase : phase_q;
      burst_d = cfg_hit ? cfgBurst : burst_q;
      case (st_q)
        S_IDLE: begin
          if (chStart[g] && !chStop[g]) begin
            hi_d    = 1'b0;
            edges_d = '0;
            // RUN is entered with an expired low half, so the next edge rises.
            if (phase_q == '0) begin
              st_d  = S_RUN;
              cnt_d = '0;
            end else begin
              st_d  = S_PHASE;
              cnt_d = phase_q;
            end
          end
        end
        S_PHASE: begin
          if (chStop[g]) begin
            st_d   = S_IDLE;
            done_d = 1'b1;
          end else if (cnt_q == H'(1)) begin
            st_d  = S_RUN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - H'(1);
          end
        end
        default: begin // S_RUN, S_STOP share the half-period counter
          if ((st_q == S_RUN) && chStop[g]) st_d = S_STOP;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - H'(1);
          end else if (hi_q) begin
            hi_d  = 1'b0;
            cnt_d = hdiv_q;
            fe_d  = 1'b1;
          end else if (run_end) begin
            st_d   = S_IDLE;
            done_d = 1'b1;
          end else begin
            hi_d  = 1'b1;
            cnt_d = hdiv_q;
            re_d  = 1'b1;
            // Free-run leaves the counter still so it cannot wrap into a match.
            if (burst_q != '0) edges_d = edges_q + B'(1);
          end
        end
      endcase
    end

    always_ff @(posedge sysClk) begin
      if (sysRst) begin
        st_q    <= S_IDLE;
        hdiv_q  <= H'(C_CLK_HDIV_N);
        phase_q <= '0;
        burst_q <= '0;
        cnt_q   <= '0;
        edges_q <= '0;
        hi_q    <= 1'b0;
        re_q    <= 1'b0;
        fe_q    <= 1'b0;
        pre_q   <= 1'b0;
        pfe_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        st_q    <= st_d;
        hdiv_q  <= hdiv_d;
        phase_q <= phase_d;
        burst_q <= burst_d;
        cnt_q   <= cnt_d;
        edges_q <= edges_d;
        hi_q    <= hi_d;
        re_q    <= re_d;
        fe_q    <= fe_d;
        pre_q   <= re_q;
        pfe_q   <= fe_q;
        done_q  <= done_d;
      end
    end

    assign gatedPseudoClock[g] = hi_q;
    assign rEdgePulse[g]       = re_q;
    assign fEdgePulse[g]       = fe_q;
    assign postREdgePulse[g]   = pre_q;
    assign postFEdgePulse[g]   = pfe_q;
    assign chBusy[g]           = (st_q != S_IDLE);
    assign chDone[g]           = done_q;
  end

endmodule

// File: tb/tb_pseudo_clock_multi.sv
// Purpose : directed checks of pseudo_clock_multi (4-channel main instance, 3-channel instance for out-of-range cfgCh).
// Latency : outputs sampled 1 time unit after each sysClk rising edge.
// Backpr. : none.
module tb_pseudo_clock_multi;

  logic        sysClk = 1'b0;
  logic        sysRst;
  logic        cfgWe;
  logic [1:0]  cfgCh;
  logic [31:0] cfgHdiv, cfgPhase;
  logic [15:0] cfgBurst;
  logic [3:0]  chStart, chStop;
  logic [3:0]  gatedPseudoClock, rEdgePulse, fEdgePulse, postREdgePulse, postFEdgePulse, chBusy, chDone;

  logic        b_we;
  logic [1:0]  b_ch;
  logic [2:0]  b_start, b_stop;
  logic [2:0]  b_gated, b_r, b_f, b_pr, b_pf, b_busy, b_done;

  logic [27:0] obs_v;
  logic [20:0] obs3;

  int n_vec = 0;
  int n_err = 0;

  always #5 sysClk = ~sysClk;

  pseudo_clock_multi #(.C_CH(4)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .cfgWe(cfgWe), .cfgCh(cfgCh),
    .cfgHdiv(cfgHdiv), .cfgPhase(cfgPhase), .cfgBurst(cfgBurst),
    .chStart(chStart), .chStop(chStop),
    .gatedPseudoClock(gatedPseudoClock), .rEdgePulse(rEdgePulse), .fEdgePulse(fEdgePulse),
    .postREdgePulse(postREdgePulse), .postFEdgePulse(postFEdgePulse),
    .chBusy(chBusy), .chDone(chDone)
  );

  pseudo_clock_multi #(.C_CH(3)) dut3 (
    .sysClk(sysClk), .sysRst(sysRst), .cfgWe(b_we), .cfgCh(b_ch),
    .cfgHdiv(cfgHdiv), .cfgPhase(cfgPhase), .cfgBurst(cfgBurst),
    .chStart(b_start), .chStop(b_stop),
    .gatedPseudoClock(b_gated), .rEdgePulse(b_r), .fEdgePulse(b_f),
    .postREdgePulse(b_pr), .postFEdgePulse(b_pf),
    .chBusy(b_busy), .chDone(b_done)
  );

  assign obs_v = {gatedPseudoClock, rEdgePulse, fEdgePulse, postREdgePulse, postFEdgePulse, chBusy, chDone};
  assign obs3  = {b_gated, b_r, b_f, b_pr, b_pf, b_busy, b_done};

  // Expected {clk, rise, fall, post-rise, post-fall} k cycles after a start with
  // zero phase and half-divisor hd; k <= 0 means no edge yet.
  function automatic logic [4:0] per(int k, int hd);
    int p, m;
    logic [4:0] v;
    v = '0;
    if (k >= 1) begin
      p = 2 * (hd + 1);
      m = (k - 1) % p;
      v[4] = (m <= hd);
      v[3] = (m == 0);
      v[2] = (m == hd + 1);
      v[1] = (m == 1);
      v[0] = (m == (hd + 2) % p) && (k > 1);
    end
    return v;
  endfunction

  function automatic logic [27:0] ev(int ch, logic g, logic r, logic f, logic pr, logic pf, logic b, logic d);
    logic [27:0] v;
    v = '0;
    v[24+ch] = g;  v[20+ch] = r;  v[16+ch] = f;  v[12+ch] = pr;
    v[8+ch]  = pf; v[4+ch]  = b;  v[ch]    = d;
    return v;
  endfunction

  function automatic logic [27:0] wave(int ch, int k, int hd, logic b, logic d);
    logic [4:0] p;
    p = per(k, hd);
    return ev(ch, p[4], p[3], p[2], p[1], p[0], b, d);
  endfunction

  task automatic chk(string tag, logic [27:0] obs, logic [27:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%07h expected=%07h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic cfg(logic [1:0] ch, logic [31:0] h, logic [31:0] p, logic [15:0] b);
    cfgWe = 1'b1; cfgCh = ch; cfgHdiv = h; cfgPhase = p; cfgBurst = b;
    tick();
    cfgWe = 1'b0;
  endtask

  initial begin
    logic [4:0] p3;
    sysRst = 1'b1; cfgWe = 1'b0; cfgCh = '0; cfgHdiv = '0; cfgPhase = '0; cfgBurst = '0;
    chStart = '0; chStop = '0; b_we = 1'b0; b_ch = '0; b_start = '0; b_stop = '0;
    tick(); tick();
    sysRst = 1'b0;
    chk("reset", obs_v, '0);
    chk("reset3", {7'b0, obs3}, '0);

    // Default hdiv=3, free-running ch0.
    chStart = 4'b0001; tick(); chStart = '0;
    chk("def_start", obs_v, ev(0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("def_k%0d", k), obs_v, wave(0, k, 3, 1, 0));
    end

    // Stop in the 2nd high cycle of the second period: finishes high and low halves.
    chStop = 4'b0001;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) chStop = '0;
      chk($sformatf("stop_j%0d", j), obs_v, ev(0, j <= 2, 0, j == 3, 0, j == 4, 1, 0));
    end
    tick(); chk("stop_done", obs_v, ev(0, 0, 0, 0, 0, 0, 0, 1));
    tick(); chk("stop_idle", obs_v, '0);

    // Burst of 2 on ch1; a write to busy ch1 mid-run must be ignored.
    cfg(2'd1, 32'd3, 32'd0, 16'd2);
    chStart = 4'b0010; tick(); chStart = '0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 2) begin
        cfgWe = 1'b1; cfgCh = 2'd1; cfgHdiv = 32'd0; cfgPhase = 32'd0; cfgBurst = 16'd0;
      end
      if (k == 3) cfgWe = 1'b0;
      if (k <= 16)      chk($sformatf("burst_k%0d", k), obs_v, wave(1, k, 3, 1, 0));
      else if (k == 17) chk("burst_done", obs_v, ev(1, 0, 0, 0, 0, 0, 0, 1));
      else              chk("burst_idle", obs_v, '0);
    end

    // Phase on ch2 (hdiv 0) alongside ch3 (hdiv 1), started together.
    cfg(2'd2, 32'd0, 32'd5, 16'd0);
    cfg(2'd3, 32'd1, 32'd0, 16'd0);
    chStart = 4'b1100; tick(); chStart = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("indep_k%0d", k), obs_v, wave(2, k - 5, 0, 1, 0) | wave(3, k, 1, 1, 0));
    end
    chStop = 4'b1100;
    for (int j = 0; j < 8; j++) begin
      tick();
      chStop = '0;
    end
    chk("indep_idle", {24'b0, chBusy}, '0);

    // Start and stop together while IDLE: nothing happens.
    chStart = 4'b0001; chStop = 4'b0001; tick(); chStart = '0; chStop = '0;
    chk("ss_0", obs_v, '0);
    tick(); chk("ss_1", obs_v, '0);

    // Stop during PHASE: immediate IDLE with chDone, no edges.
    cfg(2'd0, 32'd3, 32'd4, 16'd0);
    chStart = 4'b0001; tick(); chStart = '0;
    chk("ph_busy0", obs_v, ev(0, 0, 0, 0, 0, 0, 1, 0));
    tick(); chk("ph_busy1", obs_v, ev(0, 0, 0, 0, 0, 0, 1, 0));
    chStop = 4'b0001; tick(); chStop = '0;
    chk("ph_done", obs_v, ev(0, 0, 0, 0, 0, 0, 0, 1));
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("ph_quiet%0d", j), obs_v, '0);
    end

    // Out-of-range channel write on the 3-channel instance is dropped.
    b_we = 1'b1; b_ch = 2'd3; cfgHdiv = 32'd0; cfgPhase = 32'd0; cfgBurst = 16'd1;
    tick(); b_we = 1'b0;
    b_start = 3'b111; tick(); b_start = '0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      p3 = per(k, 3);
      chk($sformatf("oor_k%0d", k), {7'b0, obs3},
          {7'b0, {3{p3[4]}}, {3{p3[3]}}, {3{p3[2]}}, {3{p3[1]}}, {3{p3[0]}}, 3'b111, 3'b000});
    end

    // Reset mid-run clears everything, and config returns to defaults.
    cfg(2'd0, 32'd1, 32'd2, 16'd0);
    chStart = 4'b0001; tick(); chStart = '0;
    tick(); tick(); tick();
    chk("rst_pre", obs_v, ev(0, 1, 1, 0, 0, 0, 1, 0));
    sysRst = 1'b1; tick();
    chk("rst_mid", obs_v, '0);
    sysRst = 1'b0; tick();
    chk("rst_after", obs_v, '0);
    chStart = 4'b0001; tick(); chStart = '0;
    chk("rst_start", obs_v, ev(0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("rst_k%0d", k), obs_v, wave(0, k, 3, 1, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
